// File: rtl/dcache_direct_mapped_pkg.sv
// Shared encodings and widths for the direct-mapped write-back data cache.
package dcache_direct_mapped_pkg;

   localparam int WORD_W     = 32;
   localparam int BLOCK_W    = 128;
   localparam int ADDR_W     = 30;
   localparam int MEM_ADDR_W = 28;
   localparam int WORDS      = BLOCK_W / WORD_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2
   } state_t;

endpackage

// File: rtl/dcache_direct_mapped_line_array.sv
// Line storage for the direct-mapped cache: valid/dirty/tag/data per index,
// one indexed read port, a full-line refill port and a single-word write port.
module cache_line_array
   import dcache_direct_mapped_pkg::*;
#(
   parameter int IDX_W = 3,
   parameter int TAG_W = MEM_ADDR_W - IDX_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IDX_W-1:0]   i_rd_idx,
   input  logic [1:0]         i_rd_off,
   output logic               o_valid,
   output logic               o_dirty,
   output logic [TAG_W-1:0]   o_tag,
   output logic [BLOCK_W-1:0] o_line,
   output logic [WORD_W-1:0]  o_word,
   input  logic               i_line_we,
   input  logic [IDX_W-1:0]   i_line_idx,
   input  logic [TAG_W-1:0]   i_line_tag,
   input  logic [BLOCK_W-1:0] i_line_data,
   input  logic               i_word_we,
   input  logic [IDX_W-1:0]   i_word_idx,
   input  logic [1:0]         i_word_off,
   input  logic [WORD_W-1:0]  i_word_data
);

   localparam int LINES = 2 ** IDX_W;

   logic [BLOCK_W-1:0] r_data [LINES];
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [LINES-1:0]   r_valid;
   logic [LINES-1:0]   r_dirty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
         for (int i = 0; i < LINES; i++) begin
            r_data[i] <= '0;
            r_tag[i]  <= '0;
         end
      end else if (i_line_we) begin
         // A refill always lands clean; any pending store merges on the following hit.
         r_data[i_line_idx]  <= i_line_data;
         r_tag[i_line_idx]   <= i_line_tag;
         r_valid[i_line_idx] <= 1'b1;
         r_dirty[i_line_idx] <= 1'b0;
      end else if (i_word_we) begin
         r_data[i_word_idx][{i_word_off, 5'b00000} +: WORD_W] <= i_word_data;
         r_dirty[i_word_idx] <= 1'b1;
      end
   end

   assign o_valid = r_valid[i_rd_idx];
   assign o_dirty = r_dirty[i_rd_idx];
   assign o_tag   = r_tag[i_rd_idx];
   assign o_line  = r_data[i_rd_idx];
   assign o_word  = r_data[i_rd_idx][{i_rd_off, 5'b00000} +: WORD_W];

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate cache between the pipeline and a 128-bit block memory.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read as zero.
module dcache_direct_mapped
   import dcache_direct_mapped_pkg::*;
#(
   parameter int IDX_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  proc_read,
   input  logic                  proc_write,
   input  logic [ADDR_W-1:0]     proc_addr,
   input  logic [WORD_W-1:0]     proc_wdata,
   output logic                  proc_stall,
   output logic [WORD_W-1:0]     proc_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [BLOCK_W-1:0]    mem_wdata,
   input  logic                  mem_ready,
   input  logic [BLOCK_W-1:0]    mem_rdata,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt
);

   localparam int TAG_W = MEM_ADDR_W - IDX_W;

   state_t             r_state;
   logic [TAG_W-1:0]   w_tag;
   logic [IDX_W-1:0]   w_idx;
   logic [1:0]         w_off;
   logic               w_req;
   logic               w_valid;
   logic               w_dirty;
   logic [TAG_W-1:0]   w_stored_tag;
   logic [BLOCK_W-1:0] w_line;
   logic [WORD_W-1:0]  w_word;
   logic               w_hit;
   logic               w_idle_hit;
   logic               w_miss_start;
   logic               w_line_we;
   logic               w_word_we;

   assign w_off = proc_addr[1:0];
   assign w_idx = proc_addr[IDX_W+1:2];
   assign w_tag = proc_addr[ADDR_W-1:IDX_W+2];
   assign w_req = proc_read | proc_write;

   cache_line_array #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_lines (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rd_idx    (w_idx),
      .i_rd_off    (w_off),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty),
      .o_tag       (w_stored_tag),
      .o_line      (w_line),
      .o_word      (w_word),
      .i_line_we   (w_line_we),
      .i_line_idx  (w_idx),
      .i_line_tag  (w_tag),
      .i_line_data (mem_rdata),
      .i_word_we   (w_word_we),
      .i_word_idx  (w_idx),
      .i_word_off  (w_off),
      .i_word_data (proc_wdata)
   );

   assign w_hit        = w_valid && (w_stored_tag == w_tag);
   assign w_idle_hit   = (r_state == ST_IDLE) && w_hit;
   assign w_miss_start = (r_state == ST_IDLE) && w_req && !w_hit;
   assign w_line_we    = (r_state == ST_ALLOCATE) && mem_ready;
   // Read+write together resolves as a write, so the store path ignores proc_read.
   assign w_word_we    = w_idle_hit && proc_write;

   assign proc_stall = w_req && !w_idle_hit;
   assign proc_rdata = w_idle_hit ? w_word : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_miss_start) begin
                  if (w_dirty) begin
                     r_state   <= ST_WRITEBACK;
                     mem_write <= 1'b1;
                     mem_addr  <= {w_stored_tag, w_idx};
                     mem_wdata <= w_line;
                  end else begin
                     r_state  <= ST_ALLOCATE;
                     mem_read <= 1'b1;
                     mem_addr <= {w_tag, w_idx};
                  end
               end
            end
            ST_WRITEBACK: begin
               if (mem_ready) begin
                  r_state   <= ST_ALLOCATE;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  mem_addr  <= {w_tag, w_idx};
               end
            end
            ST_ALLOCATE: begin
               if (mem_ready) begin
                  r_state  <= ST_IDLE;
                  mem_read <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_idle_hit && w_req)
            r_hit_cnt <= sat_inc(r_hit_cnt);
         if (w_miss_start)
            r_miss_cnt <= sat_inc(r_miss_cnt);
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped: flat-memory golden model plus residency directory,
// a latency-LAT block memory responder, and per-cycle output comparison.
module tb_dcache_direct_mapped;

   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_ready;
   logic [127:0] mem_rdata;
   logic [31:0]  hit_cnt;
   logic [31:0]  miss_cnt;

   always #5 clk = ~clk;

   dcache_direct_mapped dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .proc_rdata (proc_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Memory as the processor must see it (golden) and as the block memory holds it (backing).
   logic [31:0] backing [bit [29:0]];
   logic [31:0] golden  [bit [29:0]];

   function automatic logic [31:0] init_word(input logic [29:0] a);
      return ({30'b0, a[1:0]} * 32'h1111_1111) + {a[29:2], 4'h0};
   endfunction

   function automatic logic [31:0] bk_word(input logic [29:0] a);
      return backing.exists(a) ? backing[a] : init_word(a);
   endfunction

   function automatic logic [31:0] gd_word(input logic [29:0] a);
      return golden.exists(a) ? golden[a] : init_word(a);
   endfunction

   function automatic logic [127:0] bk_block(input logic [27:0] b);
      return {bk_word({b, 2'd3}), bk_word({b, 2'd2}), bk_word({b, 2'd1}), bk_word({b, 2'd0})};
   endfunction

   function automatic logic [127:0] gd_block(input logic [27:0] b);
      return {gd_word({b, 2'd3}), gd_word({b, 2'd2}), gd_word({b, 2'd1}), gd_word({b, 2'd0})};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Which block each index holds, whether it was modified, and which phase the miss handling is in.
   int          m_phase = 0;  // 0 serving, 1 writing back, 2 fetching
   logic        dv [8];
   logic [24:0] dt [8];
   logic        dd [8];
   int unsigned m_hits = 0;
   int unsigned m_misses = 0;

   function automatic logic model_hit(input logic [29:0] a);
      return dv[a[4:2]] && (dt[a[4:2]] == a[29:5]);
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0;
            for (int i = 0; i < 8; i++) begin
               dv[i] = 1'b0;
               dt[i] = '0;
               dd[i] = 1'b0;
            end
            m_hits   = 0;
            m_misses = 0;
            golden.delete();
            foreach (backing[k]) golden[k] = backing[k];
         end else begin
            case (m_phase)
               0: if (proc_read || proc_write) begin
                  if (model_hit(proc_addr)) begin
                     m_hits++;
                     if (proc_write) begin
                        golden[proc_addr] = proc_wdata;
                        dd[proc_addr[4:2]] = 1'b1;
                     end
                  end else begin
                     m_misses++;
                     m_phase = (dv[proc_addr[4:2]] && dd[proc_addr[4:2]]) ? 1 : 2;
                  end
               end
               1: if (mem_ready) m_phase = 2;
               default: if (mem_ready) begin
                  dv[proc_addr[4:2]] = 1'b1;
                  dt[proc_addr[4:2]] = proc_addr[29:5];
                  dd[proc_addr[4:2]] = 1'b0;
                  m_phase = 0;
               end
            endcase
         end
      end
   end

   // Block memory: answers each request LAT cycles after it is seen, abandons it on reset.
   initial begin
      int  cnt;
      bit  busy;
      cnt       = 0;
      busy      = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy      = 1'b0;
            mem_ready = 1'b0;
         end else if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (!busy && (mem_read || mem_write)) begin
            busy = 1'b1;
            cnt  = LAT;
            if (mem_write)
               for (int k = 0; k < 4; k++) backing[{mem_addr, k[1:0]}] = mem_wdata[32*k +: 32];
         end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
               busy      = 1'b0;
               mem_ready = 1'b1;
               mem_rdata = bk_block(mem_addr);
            end
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   initial begin
      logic       c_req;
      logic       c_stall;
      logic [2:0] c_idx;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1) begin
            c_req   = proc_read | proc_write;
            c_idx   = proc_addr[4:2];
            c_stall = c_req && !(m_phase == 0 && model_hit(proc_addr));
            chk("stall", proc_stall, c_stall);
            chk("mem_read", mem_read, m_phase == 2);
            chk("mem_write", mem_write, m_phase == 1);
            if (m_phase == 1) begin
               chk("wb_addr", mem_addr, {dt[c_idx], c_idx});
               chk("wb_data", mem_wdata, gd_block({dt[c_idx], c_idx}));
            end
            if (m_phase == 2)
               chk("fetch_addr", mem_addr, proc_addr[29:2]);
            if (proc_read && !proc_write && !c_stall)
               chk("rdata", proc_rdata, gd_word(proc_addr));
`ifdef DCACHE_STATS_EN
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
`else
            chk("hit_cnt", hit_cnt, 0);
            chk("miss_cnt", miss_cnt, 0);
`endif
         end
      end
   end

   task automatic wait_unstall(input string name);
      int n;
      n = 0;
      while (proc_stall === 1'b1 && n < 60) begin
         @(negedge clk);
         #2;
         n++;
      end
      checks++;
      if (proc_stall !== 1'b0) begin
         errors++;
         $display("FAIL %s: stall=%b after %0d cycles, required 0", name, proc_stall, n);
      end
   endtask

   task automatic wait_mem_read(input string name);
      int n;
      n = 0;
      while (mem_read !== 1'b1 && n < 60) begin
         @(negedge clk);
         #2;
         n++;
      end
      checks++;
      if (mem_read !== 1'b1) begin
         errors++;
         $display("FAIL %s: mem_read=%b after %0d cycles, required 1", name, mem_read, n);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_mem_addr", mem_addr, 28'h0);
      chk("rst_mem_wdata", mem_wdata, 128'h0);
      chk("rst_rdata", proc_rdata, 32'h0);
      chk("rst_hit_cnt", hit_cnt, 32'h0);
      chk("rst_miss_cnt", miss_cnt, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cold read miss and refill of block 0.
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = 30'h0;
      #2;
      chk("t1_stall", proc_stall, 1'b1);
      @(negedge clk);
      #2;
      chk("t1_mem_read", mem_read, 1'b1);
      chk("t1_mem_addr", mem_addr, 28'h0);
      wait_unstall("t1_refill");
      chk("t1_rdata", proc_rdata, 32'h0000_0000);

      // Hit on the refilled line.
      @(negedge clk);
      proc_addr = 30'h2;
      #2;
      chk("t2_stall", proc_stall, 1'b0);
      chk("t2_rdata", proc_rdata, 32'h2222_2222);

      // Write hit, then read it back.
      @(negedge clk);
      proc_read  = 1'b0;
      proc_write = 1'b1;
      proc_addr  = 30'h1;
      proc_wdata = 32'hDEAD_BEEF;
      #2;
      chk("t3_wr_stall", proc_stall, 1'b0);
      @(negedge clk);
      proc_write = 1'b0;
      proc_read  = 1'b1;
      #2;
      chk("t3_rdata", proc_rdata, 32'hDEAD_BEEF);
      chk("t3_mem_write", mem_write, 1'b0);

      // Conflict miss on a dirty line: write-back then fetch.
      @(negedge clk);
      proc_addr = 30'h20;
      #2;
      chk("t4_stall", proc_stall, 1'b1);
      @(negedge clk);
      #2;
      chk("t4_mem_write", mem_write, 1'b1);
      chk("t4_wb_addr", mem_addr, 28'h0);
      chk("t4_wb_data", mem_wdata, 128'h33333333_22222222_DEADBEEF_00000000);
      wait_mem_read("t4_fetch");
      chk("t4_fetch_addr", mem_addr, 28'h8);
      chk("t4_no_write", mem_write, 1'b0);
      wait_unstall("t4_refill");
      chk("t4_rdata", proc_rdata, 32'h0000_0080);
`ifndef DCACHE_STATS_EN
      chk("t4_hit_cnt", hit_cnt, 32'h0);
      chk("t4_miss_cnt", miss_cnt, 32'h0);
`endif

      // Reset while fetching a clean-victim miss.
      @(negedge clk);
      proc_addr = 30'h40;
      @(negedge clk);
      #2;
      chk("t5_mem_read", mem_read, 1'b1);
      chk("t5_fetch_addr", mem_addr, 28'h10);
      @(negedge clk);
      rst_n     = 1'b0;
      proc_read = 1'b0;
      #1;
      chk("t5_rst_mem_read", mem_read, 1'b0);
      chk("t5_rst_mem_write", mem_write, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = 30'h2;
      #2;
      chk("t5_post_rst_miss", proc_stall, 1'b1);
      wait_unstall("t5_refill");
      chk("t5_rdata", proc_rdata, 32'h2222_2222);

      // Read and write together act as a write.
      @(negedge clk);
      proc_write = 1'b1;
      proc_addr  = 30'h3;
      proc_wdata = 32'h1234_5678;
      #2;
      chk("t6_rw_stall", proc_stall, 1'b0);
      @(negedge clk);
      proc_write = 1'b0;
      #2;
      chk("t6_rdata", proc_rdata, 32'h1234_5678);

      // Idle: no request never stalls.
      @(negedge clk);
      proc_read = 1'b0;
      proc_addr = 30'h3FF;
      #2;
      chk("t7_idle_stall", proc_stall, 1'b0);
      repeat (2) @(negedge clk);
      #2;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
